hp1349a_control_p: RTL and testbench

- Parametrised successor command interpreter for the HP1349A display emulation.
- Consumes 16-bit HP1349A command words over a valid/ready stream, maintains pen and graph state, and emits scaled vector/character draw requests to the raster drawing engine over a valid/ready handshake.
- Adds set-condition (intensity, character size) and CR/LF text control to the base command set.
- Output resolution and device coordinate width are parameters.

---
 rtl/hp1349a_pkg.sv | 32 +++
 rtl/hp1349a_scale.sv | 25 ++
 rtl/hp1349a_control_p.sv | 215 +++++++++++++++++++++
 tb/tb_hp1349a_control_p.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp1349a_pkg.sv
// Shared constants and types for the HP1349A command interpreter.
package hp1349a_pkg;

    // Command opcodes held in cmd_data[14:13]
    localparam logic [1:0] OP_PLOT    = 2'b00;
    localparam logic [1:0] OP_GRAPH   = 2'b01;
    localparam logic [1:0] OP_TEXT    = 2'b10;
    localparam logic [1:0] OP_SETCOND = 2'b11;

    // Text control codes that move the pen instead of drawing
    localparam logic [6:0] CODE_CR = 7'h0D;
    localparam logic [6:0] CODE_LF = 7'h0A;

    // Values driven on draw_kind
    localparam logic KIND_VECTOR = 1'b0;
    localparam logic KIND_CHAR   = 1'b1;

    // One command word is carried through these states in order
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_SCALE,
        ST_EMIT,
        ST_COMMIT
    } state_t;

    // Set-condition words only use [12] and the low data bits; anything in [11:7] is rejected
    function automatic logic isUnsupported(input logic [14:0] word);
        return (word[14:13] == OP_SETCOND) && (word[11:7] != 5'd0);
    endfunction

endpackage

// File: rtl/hp1349a_scale.sv
// Maps one device coordinate onto the screen: (c * SIZE) >> COORD_W, optionally flipped.
module hp1349a_scale #(
    parameter int COORD_W = 11,
    parameter int OUT_W   = 10,
    parameter int SIZE    = 640,
    parameter bit INVERT  = 1'b0
) (
    input  logic [COORD_W-1:0] coord_i,
    output logic [OUT_W-1:0]   screen_o
);

    // Product is kept wide enough that nothing is lost before the shift
    localparam int PW = COORD_W + $clog2(SIZE) + 1;

    logic [PW-1:0] product;
    logic [PW-1:0] shifted;

    // Full-width multiply, then drop the device fraction; y axis counts down from the top row
    always_comb begin
        product  = PW'(coord_i) * PW'(SIZE);
        shifted  = product >> COORD_W;
        screen_o = OUT_W'(INVERT ? (PW'(SIZE - 1) - shifted) : shifted);
    end

endmodule

// File: rtl/hp1349a_control_p.sv
// HP1349A command interpreter: decodes command words, tracks pen/graph/condition state
// and hands scaled vector or character requests to the raster engine.
module hp1349a_control_p
    import hp1349a_pkg::*;
#(
    parameter int COORD_W  = 11,
    parameter int OUT_W    = 10,
    parameter int SCR_W    = 640,
    parameter int SCR_H    = 480,
    parameter int CHAR_ADV = 30,
    parameter int LINE_ADV = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_data,
    output logic             draw_valid,
    input  logic             draw_ready,
    output logic             draw_kind,
    output logic [OUT_W-1:0] draw_x_from,
    output logic [OUT_W-1:0] draw_y_from,
    output logic [OUT_W-1:0] draw_x_to,
    output logic [OUT_W-1:0] draw_y_to,
    output logic [6:0]       draw_char_code,
    output logic [6:0]       draw_intensity,
    output logic [1:0]       draw_char_size,
    output logic             cmd_error
);

    localparam logic [COORD_W-1:0] CMAX = '1;

    state_t state_q, state_d;
    logic [14:0] cmdWord_q, cmdWord_d;
    logic [COORD_W-1:0] penX_q, penX_d, penY_q, penY_d;
    logic [COORD_W-1:0] latchX_q, latchX_d, lineStartX_q, lineStartX_d;
    logic [COORD_W-1:0] graphX_q, graphX_d, graphInc_q, graphInc_d;
    logic [6:0] intensity_q, intensity_d;
    logic [1:0] charSize_q, charSize_d;
    logic [OUT_W-1:0] sFromX_q, sFromX_d, sFromY_q, sFromY_d;
    logic [OUT_W-1:0] sToX_q, sToX_d, sToY_q, sToY_d;

    logic [OUT_W-1:0] scFromX, scFromY, scToX, scToY;
    logic [COORD_W-1:0] toXSrc, charStep, lineStep;

    logic unusedMsb;
    assign unusedMsb = cmd_data[15];

    logic [1:0] opcode;
    logic subBit, penBit, isText, isCtrl, unsupported, wantsDraw;
    logic [COORD_W-1:0] field;
    logic [6:0] code;

    assign opcode      = cmdWord_q[14:13];
    assign subBit      = cmdWord_q[12];
    assign penBit      = cmdWord_q[11];
    assign field       = COORD_W'(cmdWord_q[10:0]);
    assign code        = cmdWord_q[6:0];
    assign isText      = (opcode == OP_TEXT);
    assign isCtrl      = (code == CODE_CR) || (code == CODE_LF);
    assign unsupported = isUnsupported(cmdWord_q);
    assign wantsDraw   = ((opcode == OP_PLOT || opcode == OP_GRAPH) && subBit && penBit)
                       || (isText && !isCtrl);

    assign toXSrc   = (opcode == OP_GRAPH) ? graphX_q : latchX_q;
    assign charStep = COORD_W'(CHAR_ADV) << charSize_q;
    assign lineStep = COORD_W'(LINE_ADV) << charSize_q;

    function automatic logic [COORD_W-1:0] satAdd(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic [COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COORD_W] ? CMAX : sum[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] satSub(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return (a < b) ? '0 : a - b;
    endfunction

    hp1349a_scale #(.COORD_W(COORD_W), .OUT_W(OUT_W), .SIZE(SCR_W), .INVERT(1'b0))
        uScaleFromX (.coord_i(penX_q), .screen_o(scFromX));
    hp1349a_scale #(.COORD_W(COORD_W), .OUT_W(OUT_W), .SIZE(SCR_H), .INVERT(1'b1))
        uScaleFromY (.coord_i(penY_q), .screen_o(scFromY));
    hp1349a_scale #(.COORD_W(COORD_W), .OUT_W(OUT_W), .SIZE(SCR_W), .INVERT(1'b0))
        uScaleToX (.coord_i(toXSrc), .screen_o(scToX));
    hp1349a_scale #(.COORD_W(COORD_W), .OUT_W(OUT_W), .SIZE(SCR_H), .INVERT(1'b1))
        uScaleToY (.coord_i(field), .screen_o(scToY));

    // Sequencing plus all state updates; pen/graph/condition state only changes in COMMIT
    always_comb begin
        state_d      = state_q;
        cmdWord_d    = cmdWord_q;
        penX_d       = penX_q;
        penY_d       = penY_q;
        latchX_d     = latchX_q;
        lineStartX_d = lineStartX_q;
        graphX_d     = graphX_q;
        graphInc_d   = graphInc_q;
        intensity_d  = intensity_q;
        charSize_d   = charSize_q;
        sFromX_d     = sFromX_q;
        sFromY_d     = sFromY_q;
        sToX_d       = sToX_q;
        sToY_d       = sToY_q;
        cmd_ready    = 1'b0;
        cmd_error    = 1'b0;
        draw_valid   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    cmdWord_d = cmd_data[14:0];
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cmd_error = unsupported;
                state_d   = wantsDraw ? ST_SCALE : ST_COMMIT;
            end
            ST_SCALE: begin
                sFromX_d = scFromX;
                sFromY_d = scFromY;
                sToX_d   = isText ? '0 : scToX;
                sToY_d   = isText ? '0 : scToY;
                state_d  = ST_EMIT;
            end
            ST_EMIT: begin
                draw_valid = 1'b1;
                if (draw_ready) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (!unsupported) begin
                    case (opcode)
                        OP_PLOT: begin
                            if (!subBit) begin
                                latchX_d     = field;
                                lineStartX_d = field;
                            end else begin
                                penX_d = latchX_q;
                                penY_d = field;
                            end
                        end
                        OP_GRAPH: begin
                            if (!subBit) begin
                                graphInc_d = field;
                                graphX_d   = '0;
                            end else begin
                                penX_d   = graphX_q;
                                penY_d   = field;
                                graphX_d = satAdd(graphX_q, graphInc_q);
                            end
                        end
                        OP_TEXT: begin
                            if (code == CODE_CR)      penX_d = lineStartX_q;
                            else if (code == CODE_LF) penY_d = satSub(penY_q, lineStep);
                            else                      penX_d = satAdd(penX_q, charStep);
                        end
                        default: begin
                            if (!subBit) intensity_d = cmdWord_q[6:0];
                            else         charSize_d  = cmdWord_q[1:0];
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any pending request and restores power-on defaults
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmdWord_q    <= '0;
            penX_q       <= '0;
            penY_q       <= '0;
            latchX_q     <= '0;
            lineStartX_q <= '0;
            graphX_q     <= '0;
            graphInc_q   <= COORD_W'(1);
            intensity_q  <= 7'h7F;
            charSize_q   <= 2'd0;
            sFromX_q     <= '0;
            sFromY_q     <= '0;
            sToX_q       <= '0;
            sToY_q       <= '0;
        end else begin
            state_q      <= state_d;
            cmdWord_q    <= cmdWord_d;
            penX_q       <= penX_d;
            penY_q       <= penY_d;
            latchX_q     <= latchX_d;
            lineStartX_q <= lineStartX_d;
            graphX_q     <= graphX_d;
            graphInc_q   <= graphInc_d;
            intensity_q  <= intensity_d;
            charSize_q   <= charSize_d;
            sFromX_q     <= sFromX_d;
            sFromY_q     <= sFromY_d;
            sToX_q       <= sToX_d;
            sToY_q       <= sToY_d;
        end
    end

    assign draw_kind      = draw_valid ? (isText ? KIND_CHAR : KIND_VECTOR) : 1'b0;
    assign draw_x_from    = draw_valid ? sFromX_q : '0;
    assign draw_y_from    = draw_valid ? sFromY_q : '0;
    assign draw_x_to      = draw_valid ? sToX_q : '0;
    assign draw_y_to      = draw_valid ? sToY_q : '0;
    assign draw_char_code = (draw_valid && isText) ? code : 7'd0;
    assign draw_intensity = draw_valid ? intensity_q : 7'd0;
    assign draw_char_size = draw_valid ? charSize_q : 2'd0;

endmodule

// File: tb/tb_hp1349a_control_p.sv
// Bench for hp1349a_control_p: hand-computed vector table, randomized words against a
// behavioural model, and a mid-request reset sequence.
module tb_hp1349a_control_p;

    localparam int COORD_W  = 11;
    localparam int OUT_W    = 10;
    localparam int SCR_W    = 640;
    localparam int SCR_H    = 480;
    localparam int CHAR_ADV = 30;
    localparam int LINE_ADV = 48;
    localparam int CMAXI    = (1 << COORD_W) - 1;

    logic clk = 1'b0;
    logic rst, cmd_valid, cmd_ready, draw_valid, draw_ready, draw_kind, cmd_error;
    logic [15:0] cmd_data;
    logic [OUT_W-1:0] draw_x_from, draw_y_from, draw_x_to, draw_y_to;
    logic [6:0] draw_char_code, draw_intensity;
    logic [1:0] draw_char_size;

    int compared = 0;
    int failed = 0;
    int xferCount = 0;
    int expXfers = 0;

    hp1349a_control_p #(
        .COORD_W(COORD_W), .OUT_W(OUT_W), .SCR_W(SCR_W), .SCR_H(SCR_H),
        .CHAR_ADV(CHAR_ADV), .LINE_ADV(LINE_ADV)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_kind(draw_kind),
        .draw_x_from(draw_x_from), .draw_y_from(draw_y_from),
        .draw_x_to(draw_x_to), .draw_y_to(draw_y_to),
        .draw_char_code(draw_char_code), .draw_intensity(draw_intensity),
        .draw_char_size(draw_char_size), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    // Counts every accepted draw request
    always @(posedge clk) begin
        if (!rst && draw_valid && draw_ready) xferCount++;
    end

    // Hard time limit so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [15:0] word;
        int  hold;
        bit  expErr;
        bit  expDraw;
        bit  kind;
        int  fx, fy, tx, ty;
        int  code, inten, size;
    } vector_t;

    vector_t vecs[$];

    task automatic addVec(input logic [15:0] w, input int hold, input bit err, input bit drw,
                          input bit kind, input int fx, input int fy, input int tx, input int ty,
                          input int code, input int inten, input int size);
        vector_t v;
        v.word = w; v.hold = hold; v.expErr = err; v.expDraw = drw; v.kind = kind;
        v.fx = fx; v.fy = fy; v.tx = tx; v.ty = ty;
        v.code = code; v.inten = inten; v.size = size;
        vecs.push_back(v);
    endtask

    // Behavioural model of the interpreter's visible state, in device units
    int mPenX, mPenY, mLatchX, mLineStart, mGraphX, mGraphInc, mInt, mSize;

    function automatic int toSx(input int c);
        return (c * SCR_W) / (1 << COORD_W);
    endfunction

    function automatic int toSy(input int c);
        return SCR_H - 1 - (c * SCR_H) / (1 << COORD_W);
    endfunction

    task automatic modelReset();
        mPenX = 0; mPenY = 0; mLatchX = 0; mLineStart = 0;
        mGraphX = 0; mGraphInc = 1; mInt = 127; mSize = 0;
    endtask

    task automatic modelStep(input logic [15:0] w, output vector_t e);
        int op = int'(w[14:13]);
        int field = int'(w[10:0]);
        int code = int'(w[6:0]);
        e = '{default: 0};
        e.word = w;
        e.inten = mInt;
        e.size = mSize;
        case (op)
            0: begin
                if (!w[12]) begin
                    mLatchX = field; mLineStart = field;
                end else begin
                    if (w[11]) begin
                        e.expDraw = 1; e.fx = toSx(mPenX); e.fy = toSy(mPenY);
                        e.tx = toSx(mLatchX); e.ty = toSy(field);
                    end
                    mPenX = mLatchX; mPenY = field;
                end
            end
            1: begin
                if (!w[12]) begin
                    mGraphInc = field; mGraphX = 0;
                end else begin
                    if (w[11]) begin
                        e.expDraw = 1; e.fx = toSx(mPenX); e.fy = toSy(mPenY);
                        e.tx = toSx(mGraphX); e.ty = toSy(field);
                    end
                    mPenX = mGraphX; mPenY = field;
                    mGraphX = (mGraphX + mGraphInc > CMAXI) ? CMAXI : mGraphX + mGraphInc;
                end
            end
            2: begin
                if (code == 13) mPenX = mLineStart;
                else if (code == 10) mPenY = (mPenY < (LINE_ADV << mSize)) ? 0 : mPenY - (LINE_ADV << mSize);
                else begin
                    e.expDraw = 1; e.kind = 1; e.code = code;
                    e.fx = toSx(mPenX); e.fy = toSy(mPenY);
                    mPenX = (mPenX + (CHAR_ADV << mSize) > CMAXI) ? CMAXI : mPenX + (CHAR_ADV << mSize);
                end
            end
            default: begin
                if (w[11:7] != 5'd0) e.expErr = 1;
                else if (!w[12]) mInt = code;
                else mSize = int'(w[1:0]);
            end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkFields(input vector_t e);
        checkOutput("drawKind", 64'(draw_kind), 64'(e.kind));
        checkOutput("xFrom", 64'(draw_x_from), 64'(e.fx));
        checkOutput("yFrom", 64'(draw_y_from), 64'(e.fy));
        checkOutput("xTo", 64'(draw_x_to), 64'(e.tx));
        checkOutput("yTo", 64'(draw_y_to), 64'(e.ty));
        checkOutput("charCode", 64'(draw_char_code), 64'(e.code));
        checkOutput("intensity", 64'(draw_intensity), 64'(e.inten));
        checkOutput("charSize", 64'(draw_char_size), 64'(e.size));
    endtask

    // Sends one word and follows it cycle by cycle against the expectation record
    task automatic applyStimulus(input vector_t e);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("idleReady", 64'(cmd_ready), 64'd1);
        cmd_data = e.word;
        cmd_valid = 1'b1;
        draw_ready = (e.hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data = 16'($urandom);
        checkOutput("errorPulse", 64'(cmd_error), 64'(e.expErr));
        checkOutput("validEarly1", 64'(draw_valid), 64'd0);
        checkOutput("fieldsIdle", {7'd0, draw_kind, draw_x_from, draw_y_from, draw_x_to, draw_y_to,
                                   draw_char_code, draw_intensity, draw_char_size}, 64'd0);
        @(posedge clk); #1;
        checkOutput("errorOnce", 64'(cmd_error), 64'd0);
        checkOutput("validEarly2", 64'(draw_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput("validAtN3", 64'(draw_valid), 64'(e.expDraw));
        if (e.expDraw) begin
            checkFields(e);
            for (int h = 0; h < e.hold; h++) begin
                cmd_valid = 1'b1;
                cmd_data = 16'h1C00;
                @(posedge clk); #1;
                checkOutput("holdValid", 64'(draw_valid), 64'd1);
                checkOutput("holdReady", 64'(cmd_ready), 64'd0);
                checkFields(e);
            end
            cmd_valid = 1'b0;
            draw_ready = 1'b1;
            @(posedge clk); #1;
            checkOutput("dropAfterXfer", 64'(draw_valid), 64'd0);
            expXfers++;
            checkOutput("xferCount", 64'(xferCount), 64'(expXfers));
        end
        draw_ready = 1'b1;
    endtask

    initial begin
        vector_t e;
        logic [15:0] w;
        int guard;

        rst = 1'b1; cmd_valid = 1'b0; cmd_data = 16'h0000; draw_ready = 1'b0;
        modelReset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetReady", 64'(cmd_ready), 64'd0);
        checkOutput("resetValid", 64'(draw_valid), 64'd0);
        checkOutput("resetError", 64'(cmd_error), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("readyAfterReset", 64'(cmd_ready), 64'd1);

        // Hand-computed table: plot, graph, text with CR/LF, set-condition, error, saturation
        addVec(16'h0400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h1C00, 10, 0, 1, 0, 0, 479, 320, 239, 0, 127, 0);
        addVec(16'h2100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h3A00, 0, 0, 1, 0, 320, 239, 0, 359, 0, 127, 0);
        addVec(16'h3A00, 2, 0, 1, 0, 0, 359, 80, 359, 0, 127, 0);
        addVec(16'h3A00, 0, 0, 1, 0, 80, 359, 160, 359, 0, 127, 0);
        addVec(16'h7001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h4041, 0, 0, 1, 1, 160, 359, 0, 0, 'h41, 127, 1);
        addVec(16'h4042, 1, 0, 1, 1, 178, 359, 0, 0, 'h42, 127, 1);
        addVec(16'h400D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h4043, 0, 0, 1, 1, 320, 359, 0, 0, 'h43, 127, 1);
        addVec(16'h6055, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h400A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h4044, 0, 0, 1, 1, 338, 382, 0, 0, 'h44, 'h55, 1);
        addVec(16'h7F80, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h9900, 0, 0, 1, 0, 357, 382, 80, 419, 0, 'h55, 1);
        addVec(16'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h2400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h3800, 0, 0, 1, 0, 80, 479, 0, 479, 0, 'h55, 1);
        addVec(16'h3800, 0, 0, 1, 0, 0, 479, 320, 479, 0, 'h55, 1);
        addVec(16'h3800, 0, 0, 1, 0, 320, 479, 639, 479, 0, 'h55, 1);
        addVec(16'h4045, 0, 0, 1, 1, 639, 479, 0, 0, 'h45, 'h55, 1);
        addVec(16'h4046, 0, 0, 1, 1, 639, 479, 0, 0, 'h46, 'h55, 1);
        addVec(16'h400A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(16'h4047, 0, 0, 1, 1, 639, 479, 0, 0, 'h47, 'h55, 1);

        foreach (vecs[i]) begin
            modelStep(vecs[i].word, e);
            applyStimulus(vecs[i]);
        end

        // Randomized words against the model
        for (int n = 0; n < 150; n++) begin
            w = 16'($urandom);
            if (w[14:13] == 2'b11 && $urandom_range(0, 3) != 0) w[11:7] = 5'd0;
            if (w[14:13] == 2'b10 && $urandom_range(0, 3) == 0)
                w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h0D : 7'h0A;
            modelStep(w, e);
            e.hold = $urandom_range(0, 3);
            applyStimulus(e);
        end

        // Move conditions away from defaults, then reset while a request is pending
        modelStep(16'h6011, e); applyStimulus(e);
        modelStep(16'h7002, e); applyStimulus(e);
        modelStep(16'h0200, e); applyStimulus(e);
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        cmd_data = 16'h1A00; cmd_valid = 1'b1; draw_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("preResetValid", 64'(draw_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rstDropValid", 64'(draw_valid), 64'd0);
        checkOutput("rstReadyLow", 64'(cmd_ready), 64'd0);
        checkOutput("rstFieldsZero", {7'd0, draw_kind, draw_x_from, draw_y_from, draw_x_to, draw_y_to,
                                      draw_char_code, draw_intensity, draw_char_size}, 64'd0);
        rst = 1'b0;
        draw_ready = 1'b1;
        modelReset();
        @(posedge clk); #1;
        checkOutput("rstNoXfer", 64'(xferCount), 64'(expXfers));

        // After reset: pen at origin, intensity 0x7F, size 0
        vecs.delete();
        addVec(16'h1C00, 0, 0, 1, 0, 0, 479, 0, 239, 0, 127, 0);
        addVec(16'h4041, 0, 0, 1, 1, 0, 239, 0, 0, 'h41, 127, 0);
        addVec(16'h4042, 0, 0, 1, 1, 9, 239, 0, 0, 'h42, 127, 0);
        foreach (vecs[i]) begin
            modelStep(vecs[i].word, e);
            applyStimulus(vecs[i]);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
